cpu_top: RTL and testbench
==========================

# cpu_top

Board-level top of a minimal single-step 8-bit processor. Each rising edge of the step key executes one 10-bit instruction taken from the slide switches against four 8-bit registers. Register contents go to the six seven-segment displays and the LEDs. The block sits directly on the board pins (clock, switches, keys, HEX, LEDR) and has no other interfaces.

## Interface
- No parameters.
- One clock; reset is synchronous and active-high. The clock port is `clk`; reset is `KEY[0]`.
- clk  in  1  system clock; all state updates on its rising edge.
- KEY  in  2  KEY[0] = reset (synchronous, active-high); KEY[1] = en, the step request, active-high, level input.
- SW  in  10  instruction word, sampled when a step is accepted.
- HEX5, HEX4, HEX3, HEX2, HEX1, HEX0  out  7 each  active-low segments, bit0 = a … bit6 = g.
- LEDR  out  10  LEDR[7:0] = R3, LEDR[8] = Z flag, LEDR[9] = C flag.

## Operation
- State: R0–R3 (8 bit), Z, C, IR (10 bit), en_q (1 bit), FSM {IDLE, EXEC}.
- Instruction fields: op = IR[9:7], rx = IR[6:5], ry = IR[4:3], imm5 = IR[4:0] zero-extended to 8 bits.
- Opcodes:
  - 000 mv: rx ← ry. Flags unchanged.
  - 001 mvi: rx ← imm5. Flags unchanged.
  - 010 add: rx ← rx + ry. C = carry-out, Z = (result == 0).
  - 011 sub: rx ← rx − ry. C = borrow (rx < ry unsigned), Z = (result == 0).
  - 100 and: rx ← rx & ry. C = 0, Z = (result == 0).
  - 101 addi: rx ← rx + imm5. C = carry-out, Z = (result == 0).
  - 110 xor: rx ← rx ^ ry. C = 0, Z = (result == 0).
  - 111 nop: no change to registers or flags.
- All arithmetic is 8-bit modulo 256. The carry is bit 8 of the 9-bit sum or difference.
- When rx == ry, the instruction reads the old value and writes the new one (e.g. add R1,R1 doubles R1).
- Displays:
  - HEX1:HEX0 = R0, HEX3:HEX2 = R1, HEX5:HEX4 = R2 (high nibble on the higher-numbered digit).
  - Combinational decode of the current register values, standard hex glyphs, active-low.
  - Required encodings: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.

## Timing
- Step detection:
  - en_q ← KEY[1] every cycle.
  - A step is accepted on an edge where FSM = IDLE, KEY[1] = 1 and en_q = 0.
- On the accepting edge: IR ← SW, FSM ← EXEC.
- On the next edge: the register and flag write occurs and FSM ← IDLE. Outputs reflect the result after that second edge.
- Latency: 2 clock edges from the first edge that samples en high.
- Rate: one instruction per en 0→1 transition, regardless of how long en stays high. A further rise during EXEC is impossible because en_q is set. A rise on the edge that returns FSM to IDLE is not accepted; it needs IDLE on that edge.
- SW changes after the accepting edge do not affect the executing instruction.
- Reset (KEY[0] = 1 at a rising edge) has priority over everything. It sets:
  - R0–R3 = 0, Z = C = 0, IR = 0, FSM = IDLE.
  - en_q = 1, so an en held high through reset does not trigger a step.
  - Reset in EXEC aborts the write.
- Reset output values: HEX0–HEX5 = 7'h40, LEDR = 10'h000.

## Test plan
- Reset with en low, then release: all HEX = 7'h40, LEDR = 0. Hold en high through reset and release: no step executes.
- SW = 10'b001_01_00010 (mvi R1,2), then pulse en high for 2 clocks: after 2 edges HEX2 = 7'h24, HEX3 = 7'h40. Holding en high for 10 cycles executes only once.
- Sequence mvi R0,31; mvi R1,31; add R0,R1 → R0 = 8'h3E, HEX1:HEX0 = 7'h30/7'h06, C = 0, Z = 0. Then add R0,R0 seven times: C = 1 whenever the 8-bit sum wraps.
- mvi R3,5; mvi R2,5; sub R3,R2 → LEDR[7:0] = 0, LEDR[8] = 1, LEDR[9] = 0. Then sub R3,R2 again → R3 = 8'hFB, C = 1, Z = 0.
- mvi R2,12; xor R2,R2 → R2 = 0, Z = 1, C = 0. Then nop (SW = 10'h380) → no state change.
- Assert reset on the EXEC cycle of an add: no write occurs and all state is cleared. The next en edge after release executes normally.

Source files
------------

// File: rtl/cpu_top.sv
// Single-step 8-bit processor: each en rise executes the instruction on SW against R0-R3.
// Result is visible two edges after en is first sampled high; there is no backpressure.
module cpu_top (
    input  logic       clk,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t     state_q;
    logic [7:0] r_q [4];
    logic       z_q;
    logic       c_q;
    logic       en_q;
    logic [9:0] ir_q;

    logic [2:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic [8:0] res_d;
    logic       wr_reg;
    logic       wr_flag;

    assign op  = ir_q[9:7];
    assign rx  = ir_q[6:5];
    assign ry  = ir_q[4:3];
    assign a   = r_q[rx];
    assign b   = r_q[ry];
    assign imm = {3'b000, ir_q[4:0]};

    // Bit 8 of res_d is the carry/borrow; it stays 0 for the logical ops.
    always_comb begin
        res_d   = '0;
        wr_reg  = 1'b1;
        wr_flag = 1'b1;
        case (op)
            3'b000: begin res_d = {1'b0, b};   wr_flag = 1'b0; end
            3'b001: begin res_d = {1'b0, imm}; wr_flag = 1'b0; end
            3'b010: res_d = {1'b0, a} + {1'b0, b};
            3'b011: res_d = {1'b0, a} - {1'b0, b};
            3'b100: res_d = {1'b0, a & b};
            3'b101: res_d = {1'b0, a} + {1'b0, imm};
            3'b110: res_d = {1'b0, a ^ b};
            default: begin wr_reg = 1'b0; wr_flag = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (KEY[0]) begin
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ir_q    <= '0;
            en_q    <= 1'b1;
            state_q <= IDLE;
        end else begin
            en_q <= KEY[1];
            case (state_q)
                IDLE: begin
                    if (KEY[1] && !en_q) begin
                        ir_q    <= SW;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (wr_reg) r_q[rx] <= res_d[7:0];
                    if (wr_flag) begin
                        c_q <= res_d[8];
                        z_q <= (res_d[7:0] == 8'h00);
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign HEX0 = seg7(r_q[0][3:0]);
    assign HEX1 = seg7(r_q[0][7:4]);
    assign HEX2 = seg7(r_q[1][3:0]);
    assign HEX3 = seg7(r_q[1][7:4]);
    assign HEX4 = seg7(r_q[2][3:0]);
    assign HEX5 = seg7(r_q[2][7:4]);
    assign LEDR = {c_q, z_q, r_q[3]};

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed scenarios followed by random instruction streams against an integer model.
module tb_cpu_top;

    logic       clk = 1'b0;
    logic [1:0] KEY = 2'b01;
    logic [9:0] SW  = '0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int checks = 0;
    int errors = 0;

    int m_r [4];
    int m_z;
    int m_c;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    cpu_top dut (
        .clk  (clk),
        .KEY  (KEY),
        .SW   (SW),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .HEX3 (HEX3),
        .HEX4 (HEX4),
        .HEX5 (HEX5),
        .LEDR (LEDR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_z = 0;
        m_c = 0;
    endtask

    // Behavioural ISA model in plain integer arithmetic.
    task automatic model_exec(input logic [9:0] ins);
        int op, rx, ry, x, y, imm, res;
        op = 0;  op[2:0]  = ins[9:7];
        rx = 0;  rx[1:0]  = ins[6:5];
        ry = 0;  ry[1:0]  = ins[4:3];
        imm = 0; imm[4:0] = ins[4:0];
        x = m_r[rx];
        y = m_r[ry];
        case (op)
            0: m_r[rx] = y;
            1: m_r[rx] = imm;
            2: begin res = x + y;   m_c = (res > 255) ? 1 : 0; m_r[rx] = res % 256; end
            3: begin m_c = (x < y) ? 1 : 0; m_r[rx] = (x - y + 256) % 256; end
            4: begin res = x & y;   m_c = 0; m_r[rx] = res; end
            5: begin res = x + imm; m_c = (res > 255) ? 1 : 0; m_r[rx] = res % 256; end
            6: begin res = x ^ y;   m_c = 0; m_r[rx] = res; end
            default: ;
        endcase
        if (op >= 2 && op <= 6) m_z = (m_r[rx] == 0) ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        int led;
        led = m_c * 512 + m_z * 256 + m_r[3];
        check({tag, ".HEX0"}, {3'b000, HEX0}, {3'b000, glyph[m_r[0] % 16]});
        check({tag, ".HEX1"}, {3'b000, HEX1}, {3'b000, glyph[m_r[0] / 16]});
        check({tag, ".HEX2"}, {3'b000, HEX2}, {3'b000, glyph[m_r[1] % 16]});
        check({tag, ".HEX3"}, {3'b000, HEX3}, {3'b000, glyph[m_r[1] / 16]});
        check({tag, ".HEX4"}, {3'b000, HEX4}, {3'b000, glyph[m_r[2] % 16]});
        check({tag, ".HEX5"}, {3'b000, HEX5}, {3'b000, glyph[m_r[2] / 16]});
        check({tag, ".LEDR"}, LEDR, led[9:0]);
    endtask

    // en held for two clocks, then low long enough for en_q to clear.
    task automatic step(input logic [9:0] ins);
        @(negedge clk);
        SW = ins;
        KEY[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        KEY[1] = 1'b0;
        model_exec(ins);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        KEY[0] = 1'b1;
        KEY[1] = en;
        repeat (3) @(negedge clk);
        KEY[0] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset with en low
        do_reset(1'b0);
        check_all("reset");
        check("reset_hex0", {3'b000, HEX0}, 10'h040);
        check("reset_ledr", LEDR, 10'h000);

        // en held through reset must not step
        SW = 10'b001_00_00101;
        do_reset(1'b1);
        check_all("reset_en_high");
        @(negedge clk);
        KEY[1] = 1'b0;
        @(negedge clk);

        // mvi R1,2
        step(10'b001_01_00010);
        check_all("mvi_r1");
        check("mvi_r1_hex2", {3'b000, HEX2}, 10'h024);
        check("mvi_r1_hex3", {3'b000, HEX3}, 10'h040);

        // Long hold of en executes addi R1,1 once; SW changes mid-execution are ignored
        @(negedge clk);
        SW = 10'b101_01_00001;
        KEY[1] = 1'b1;
        @(negedge clk);
        SW = 10'b001_01_11111;
        repeat (9) @(negedge clk);
        KEY[1] = 1'b0;
        model_exec(10'b101_01_00001);
        @(negedge clk);
        check_all("hold_once");
        check("hold_once_hex2", {3'b000, HEX2}, 10'h030);

        // mvi R0,31; mvi R1,31; add R0,R1
        step(10'b001_00_11111);
        step(10'b001_01_11111);
        step(10'b010_00_01_000);
        check_all("add_r0r1");
        check("add_hex1", {3'b000, HEX1}, 10'h030);
        check("add_hex0", {3'b000, HEX0}, 10'h006);
        for (int i = 0; i < 7; i++) begin
            step(10'b010_00_00_000);
            check_all($sformatf("dbl%0d", i));
        end

        // mvi R3,5; mvi R2,5; sub R3,R2 twice
        step(10'b001_11_00101);
        step(10'b001_10_00101);
        step(10'b011_11_10_000);
        check_all("sub_zero");
        check("sub_zero_ledr", LEDR, 10'h100);
        step(10'b011_11_10_000);
        check_all("sub_borrow");
        check("sub_borrow_ledr", LEDR, 10'h2FB);

        // mvi R2,12; xor R2,R2; nop
        step(10'b001_10_01100);
        step(10'b110_10_10_000);
        check_all("xor_self");
        step(10'h380);
        check_all("nop");

        // Reset during EXEC aborts the write
        @(negedge clk);
        SW = 10'b010_00_01_000;
        KEY[1] = 1'b1;
        @(negedge clk);
        KEY[0] = 1'b1;
        @(negedge clk);
        KEY[0] = 1'b0;
        KEY[1] = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("reset_exec");
        step(10'b001_10_00111);
        check_all("after_reset_exec");

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            step(10'($urandom_range(0, 1023)));
            check_all($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
